// File: rtl/hazard_pkg.sv
// Shared types for the hazard/pipeline control slice: register address type,
// per-stage destination control record and the bubble constant.
package hazard_pkg;

  localparam int REG_W    = 5;
  localparam int ZERO_REG = 31;

  typedef logic [REG_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t dest;
    logic      regwr;
    logic      memrd;
  } stage_ctl_t;

  localparam stage_ctl_t BUBBLE = '{dest: reg_addr_t'(ZERO_REG), regwr: 1'b0, memrd: 1'b0};

endpackage

// File: rtl/pipe_ctl_reg.sv
// One pipeline-stage control register: holds when en=0, loads BUBBLE or d otherwise.
module pipe_ctl_reg
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       bubble,
  input  stage_ctl_t d,
  output stage_ctl_t q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= BUBBLE;
    end else if (en) begin
      q <= bubble ? BUBBLE : d;
    end
  end

endmodule

// File: rtl/hazard_pipe_ctl.sv
// Destination tracking for EX/MEM/WB, load-use stall, branch flush and memory freeze.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_pipe_ctl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwr,
  input  logic             id_memrd,
  input  logic             flush,
  input  logic             mem_busy,
  output logic [REG_W-1:0] dest_ex,
  output logic             regwr_ex,
  output logic             memrd_ex,
  output logic [REG_W-1:0] dest_mem,
  output logic             regwr_mem,
  output logic [REG_W-1:0] dest_wb,
  output logic             regwr_wb,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
`endif
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush
);

  import hazard_pkg::*;

  localparam logic [REG_W-1:0] XZR = REG_W'(ZERO_REG);

  stage_ctl_t ex_p0, mem_p1, wb_p2;
  stage_ctl_t id_ctl;
  logic       lu, lu_win, flush_win, stall_q, advance;
  logic       unused_wb_memrd;

  assign unused_wb_memrd = wb_p2.memrd;

  // The stall flag is redundant with the EX bubble but guarantees a stall never exceeds one cycle.
  assign lu = id_valid & ex_p0.regwr & ex_p0.memrd & (ex_p0.dest != XZR) & ~stall_q &
              ((id_use_rn & (id_rn == ex_p0.dest)) | (id_use_rm & (id_rm == ex_p0.dest)));

  assign advance   = ~mem_busy;
  assign flush_win = advance & flush;
  assign lu_win    = advance & ~flush & lu;

  assign id_ctl.dest  = id_rd;
  assign id_ctl.regwr = id_regwr & id_valid & (id_rd != XZR);
  assign id_ctl.memrd = id_memrd & id_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= 1'b0;
    end else if (advance) begin
      stall_q <= lu_win;
    end
  end

  // ---- ID -> EX ----
  pipe_ctl_reg u_ex (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (advance),
    .bubble  (flush | lu),
    .d       (id_ctl),
    .q       (ex_p0)
  );

  // ---- EX -> MEM ----
  pipe_ctl_reg u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (advance),
    .bubble  (1'b0),
    .d       (ex_p0),
    .q       (mem_p1)
  );

  // ---- MEM -> WB ----
  pipe_ctl_reg u_wb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (advance),
    .bubble  (1'b0),
    .d       (mem_p1),
    .q       (wb_p2)
  );

  assign dest_ex   = ex_p0.dest;
  assign regwr_ex  = ex_p0.regwr;
  assign memrd_ex  = ex_p0.memrd;
  assign dest_mem  = mem_p1.dest;
  assign regwr_mem = mem_p1.regwr;
  assign dest_wb   = wb_p2.dest;
  assign regwr_wb  = wb_p2.regwr;

  assign pc_we      = advance & ~lu_win;
  assign ifid_we    = advance & ~lu_win;
  assign ifid_flush = flush_win;

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (lu_win)    stall_cnt  <= sat_inc(stall_cnt);
      if (flush_win) flush_cnt  <= sat_inc(flush_cnt);
      if (mem_busy)  freeze_cnt <= sat_inc(freeze_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_pipe_ctl.sv
// Directed bench for hazard_pipe_ctl with hand-computed expectations.
module tb_hazard_pipe_ctl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid, id_use_rn, id_use_rm, id_regwr, id_memrd;
  logic [4:0] id_rn, id_rm, id_rd;
  logic       flush, mem_busy;
  logic [4:0] dest_ex, dest_mem, dest_wb;
  logic       regwr_ex, memrd_ex, regwr_mem, regwr_wb;
  logic       pc_we, ifid_we, ifid_flush;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  hazard_pipe_ctl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .id_valid   (id_valid),
    .id_rn      (id_rn),
    .id_rm      (id_rm),
    .id_use_rn  (id_use_rn),
    .id_use_rm  (id_use_rm),
    .id_rd      (id_rd),
    .id_regwr   (id_regwr),
    .id_memrd   (id_memrd),
    .flush      (flush),
    .mem_busy   (mem_busy),
    .dest_ex    (dest_ex),
    .regwr_ex   (regwr_ex),
    .memrd_ex   (memrd_ex),
    .dest_mem   (dest_mem),
    .regwr_mem  (regwr_mem),
    .dest_wb    (dest_wb),
    .regwr_wb   (regwr_wb),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
    .freeze_cnt (freeze_cnt),
`endif
    .pc_we      (pc_we),
    .ifid_we    (ifid_we),
    .ifid_flush (ifid_flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else pass_cnt++;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rn, input logic urn,
                        input logic [4:0] rm, input logic urm,
                        input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = v; id_rn = rn; id_use_rn = urn; id_rm = rm; id_use_rm = urm;
    id_rd = rd; id_regwr = rw; id_memrd = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; mem_busy = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #12;
    check("rst_dest_ex", 32'(dest_ex), 32'd31);
    check("rst_dest_mem", 32'(dest_mem), 32'd31);
    check("rst_dest_wb", 32'(dest_wb), 32'd31);
    check("rst_flags", {29'd0, regwr_ex, memrd_ex, regwr_mem | regwr_wb}, 32'd0);
    check("rst_pc_we", 32'(pc_we), 32'd1);
    reset_n = 1'b1;
    tick();

    // load-use on Rn
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    check("lu_load_ex", {27'd0, dest_ex}, 32'd5);
    check("lu_memrd_ex", 32'(memrd_ex), 32'd1);
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    check("lu_pc_we", 32'(pc_we), 32'd0);
    check("lu_ifid_we", 32'(ifid_we), 32'd0);
    check("lu_ifid_flush", 32'(ifid_flush), 32'd0);
    tick();
    check("lu_bubble_rw", 32'(regwr_ex), 32'd0);
    check("lu_bubble_dest", 32'(dest_ex), 32'd31);
    check("lu_dest_mem", 32'(dest_mem), 32'd5);
    check("lu_regwr_mem", 32'(regwr_mem), 32'd1);
    check("lu_release_pc", 32'(pc_we), 32'd1);
    tick();
    check("lu_add_ex", 32'(dest_ex), 32'd6);
    check("lu_dest_wb", 32'(dest_wb), 32'd5);

    // load to XZR never stalls and is not a live destination
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b1, 1'b1);
    tick();
    check("xzr_regwr_ex", 32'(regwr_ex), 32'd0);
    set_id(1'b1, 5'd31, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    check("xzr_no_stall", 32'(pc_we), 32'd1);

    // ADD X7 travels EX -> MEM -> WB
    tick();
    check("add_ex", {26'd0, regwr_ex, dest_ex}, {26'd0, 1'b1, 5'd7});
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    check("add_mem", {26'd0, regwr_mem, dest_mem}, {26'd0, 1'b1, 5'd7});
    check("invalid_bubble", 32'(regwr_ex), 32'd0);
    tick();
    check("add_wb", {26'd0, regwr_wb, dest_wb}, {26'd0, 1'b1, 5'd7});

    // flush wins over load-use
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    flush = 1'b1; #1;
    check("fl_ifid_flush", 32'(ifid_flush), 32'd1);
    check("fl_pc_we", 32'(pc_we), 32'd1);
    check("fl_ifid_we", 32'(ifid_we), 32'd1);
    tick();
    flush = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("fl_ex_bubble", {27'd0, regwr_ex, memrd_ex, 1'b0} | 32'(dest_ex) << 3, 32'd31 << 3);
    check("fl_dest_mem", 32'(dest_mem), 32'd5);
    check("fl_no_stall", 32'(pc_we), 32'd1);

    // freeze for 3 cycles with EX=3, MEM=4
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    mem_busy = 1'b1; flush = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      check("fz_pc_we", 32'(pc_we), 32'd0);
      check("fz_ifid", {30'd0, ifid_we, ifid_flush}, 32'd0);
      tick();
      check("fz_dest_ex", 32'(dest_ex), 32'd3);
      check("fz_dest_mem", 32'(dest_mem), 32'd4);
    end
    mem_busy = 1'b0; flush = 1'b0; #1;
    tick();
    check("fz_resume_ex", 32'(dest_ex), 32'd9);
    check("fz_resume_mem", 32'(dest_mem), 32'd3);
    check("fz_resume_wb", 32'(dest_wb), 32'd4);

    // async reset during a load-use stall on Rm
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    check("rm_lu_pc_we", 32'(pc_we), 32'd0);
    #2 reset_n = 1'b0; #1;
    check("ar_dests", {17'd0, dest_ex, dest_mem, dest_wb}, {17'd0, 5'd31, 5'd31, 5'd31});
    check("ar_flags", {28'd0, regwr_ex, memrd_ex, regwr_mem, regwr_wb}, 32'd0);
    check("ar_pc_we", 32'(pc_we), 32'd1);
    #1 reset_n = 1'b1;
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    check("post_rst_normal", 32'(dest_ex), 32'd5);

    // two load-use stalls then one flush (counter scenario)
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    check("cnt_stall1", 32'(pc_we), 32'd0);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    check("cnt_stall2", 32'(pc_we), 32'd0);
    tick();
    flush = 1'b1; #1;
    tick();
    flush = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt", stall_cnt, 32'd2);
    check("flush_cnt", flush_cnt, 32'd1);
    check("freeze_cnt", freeze_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_pipe_ctl.md
Name: hazard_pipe_ctl

Overview:
- Tracks destination-register control (Rd, RegWrite, MemRead) of in-flight instructions through the EX, MEM and WB stages of the 5-stage LEGv8 pipeline.
- Supplies dest_ex/regwr_ex/dest_mem/regwr_mem directly to the forwarding unit downstream.
- Detects load-use hazards and inserts a one-cycle bubble.
- Applies branch flush and memory-busy freeze. Its stall outputs drive the PC and IF/ID write enables.

Parameters:
- REG_W, 5, register address width.
- ZERO_REG, 31, XZR index; never a hazard source or destination.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rn  in  REG_W  source A of the ID instruction
- id_rm  in  REG_W  source B of the ID instruction
- id_use_rn  in  1  ID instruction reads Rn
- id_use_rm  in  1  ID instruction reads Rm
- id_rd  in  REG_W  destination of the ID instruction
- id_regwr  in  1  ID instruction writes Rd
- id_memrd  in  1  ID instruction is a load
- flush  in  1  branch taken (resolved in EX); kill the ID and IF instructions
- mem_busy  in  1  data memory not ready; freeze the whole pipeline
- dest_ex  out  REG_W  Rd in EX
- regwr_ex  out  1
- memrd_ex  out  1
- dest_mem  out  REG_W  Rd in MEM
- regwr_mem  out  1
- dest_wb  out  REG_W  Rd in WB
- regwr_wb  out  1
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID register write enable
- ifid_flush  out  1  clear the IF/ID register

Behaviour:
- Reset (async, reset_n=0):
  - all dest_* = ZERO_REG; all regwr_*/memrd_ex = 0.
  - Internal stall flag = 0; counters = 0.
  - Combinational outputs reflect these values immediately.
- Load-use hazard (combinational): lu = id_valid & regwr_ex & memrd_ex & (dest_ex != ZERO_REG) & ((id_use_rn & id_rn==dest_ex) | (id_use_rm & id_rm==dest_ex)).
- Priority per cycle: mem_busy > flush > lu > normal.
- mem_busy=1:
  - All stage registers hold.
  - pc_we=0, ifid_we=0, ifid_flush=0.
  - flush and lu are ignored that cycle and re-evaluated once mem_busy drops.
- flush=1 (mem_busy=0):
  - EX loads a bubble (dest=ZERO_REG, regwr=0, memrd=0).
  - MEM<-EX, WB<-MEM.
  - pc_we=1, ifid_we=1, ifid_flush=1.
- lu=1 (no flush, no busy):
  - EX loads a bubble; MEM<-EX, WB<-MEM.
  - pc_we=0, ifid_we=0, ifid_flush=0.
  - Next cycle the load sits in MEM, so lu deasserts and the forwarding unit supplies the value from MEM. The stall therefore lasts exactly 1 cycle per hazard.
- Normal:
  - EX<-{id_rd, id_regwr & id_valid, id_memrd & id_valid}; MEM<-EX; WB<-MEM.
  - pc_we=1, ifid_we=1.
- id_valid=0 shifts a bubble into EX and never raises lu.
- An ID instruction whose id_rd==ZERO_REG with id_regwr=1 is stored with regwr=0, so XZR never appears as a live destination.
- Latency: an ID instruction reaches EX one cycle after acceptance and WB two cycles later. There are no combinational paths from flush or mem_busy to the dest_*/regwr_* outputs.
- Reset asserted mid-stall or mid-freeze clears everything; the first cycle after release is a normal cycle.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[CNT_W], flush_cnt[CNT_W] and freeze_cnt[CNT_W].
  - Each increments once per cycle in which its condition wins the priority.
  - Saturates at all-ones; reset to 0.
- Undefined: the counters and their ports are absent; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - localparam ZERO_REG;
  - typedef reg_addr_t (logic [REG_W-1:0]);
  - packed struct stage_ctl_t {reg_addr_t dest; logic regwr; logic memrd;};
  - constant BUBBLE (dest=ZERO_REG, all flags 0).
- Sub-module pipe_ctl_reg: one stage_ctl_t register with async reset_n, hold enable and bubble-load input. It is instantiated for EX, MEM and WB.

Test Plan:
- Load X5 in EX (memrd_ex=1, dest_ex=5); ID reads rn=5 -> cycle 0: pc_we=0, ifid_we=0. Cycle 1: regwr_ex=0, dest_mem=5, pc_we=1.
- Load X31 in EX; ID reads rn=31 -> no stall, pc_we=1.
- ID ADD rd=7 -> X7 appears at dest_ex/mem/wb on cycles 1/2/3 with regwr=1.
- Same cycle as a load-use match, assert flush=1 -> ifid_flush=1, pc_we=1, EX gets BUBBLE, no stall on the next cycle.
- mem_busy=1 for 3 cycles with dest_ex=3, dest_mem=4 -> both outputs unchanged and pc_we=0 throughout; normal shift resumes on the 4th cycle.
- Drop reset_n during a load-use stall -> all dest_*=31, regwr_*=0 immediately, no clock edge needed.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls and 1 flush -> stall_cnt=2, flush_cnt=1.
